// File: rtl/frame_buffer_pingpong.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_buffer_pingpong: two-bank frame store, writer fills !rBank, reader owns rBank
// Revision: 1.0
// ---------------------------------------------------------------------------
module frame_buffer_pingpong #(
   parameter int IMG_WIDTH  = 160,
   parameter int IMG_HEIGHT = 120,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] wAddr,
   input  logic [DATA_WIDTH-1:0] wData,
   input  logic                  wFrameDone,
   output logic                  wReady,
   input  logic                  oe,
   input  logic [ADDR_WIDTH-1:0] rAddr,
   input  logic                  rFrameStart,
   output logic [DATA_WIDTH-1:0] rData,
   output logic                  rValid,
   output logic                  frameReady,
   output logic                  rBank,
   output logic [15:0]           dropCount
);

   localparam int                DEPTH   = IMG_WIDTH*IMG_HEIGHT;
   localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);

   typedef enum logic [0:0] {
      ST_WRITE     = 1'b0,
      ST_WAIT_SWAP = 1'b1
   } state_t;

   logic [DATA_WIDTH-1:0] mem0_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem1_q [DEPTH];

   state_t                state_q, state_d;
   logic                  rBank_q, rBank_d;
   logic                  frameReady_q, frameReady_d;
   logic                  wReady_q, wReady_d;
   logic [15:0]           dropCount_q, dropCount_d;
   logic [DATA_WIDTH-1:0] rData_q;
   logic                  rValid_q;

   logic wrInRange, rdInRange, swap, wrEn;

   assign wrInRange = ({1'b0, wAddr} < DEPTH_X);
   assign rdInRange = ({1'b0, rAddr} < DEPTH_X);
   // A completed frame is either already pending or being completed right now.
   assign swap      = rFrameStart && (frameReady_q || (state_q == ST_WRITE && wFrameDone));
   assign wrEn      = !reset && we && wrInRange && (state_q == ST_WRITE);

   always_comb begin
      state_d      = state_q;
      rBank_d      = rBank_q;
      frameReady_d = frameReady_q;
      dropCount_d  = dropCount_q;
      if (swap) begin
         rBank_d      = !rBank_q;
         frameReady_d = 1'b0;
         state_d      = ST_WRITE;
      end else if (wFrameDone) begin
         if (state_q == ST_WRITE) begin
            state_d      = ST_WAIT_SWAP;
            frameReady_d = 1'b1;
         end else if (dropCount_q != 16'hFFFF) begin
            dropCount_d = dropCount_q + 16'd1;
         end
      end
      wReady_d = (state_d == ST_WRITE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_WRITE;
         rBank_q      <= 1'b0;
         frameReady_q <= 1'b0;
         wReady_q     <= 1'b1;
         dropCount_q  <= 16'd0;
      end else begin
         state_q      <= state_d;
         rBank_q      <= rBank_d;
         frameReady_q <= frameReady_d;
         wReady_q     <= wReady_d;
         dropCount_q  <= dropCount_d;
      end
   end

   // Storage is deliberately not reset; contents survive a reset.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         if (rBank_q) mem0_q[wAddr] <= wData;
         else         mem1_q[wAddr] <= wData;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rValid_q <= 1'b0;
         rData_q  <= '0;
      end else if (oe) begin
         rValid_q <= 1'b1;
         if (!rdInRange)   rData_q <= '0;
         else if (rBank_q) rData_q <= mem1_q[rAddr];
         else              rData_q <= mem0_q[rAddr];
      end else begin
         rValid_q <= 1'b0;
      end
   end

   assign wReady     = wReady_q;
   assign frameReady = frameReady_q;
   assign rBank      = rBank_q;
   assign dropCount  = dropCount_q;
   assign rData      = rData_q;
   assign rValid     = rValid_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_pingpong.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_frame_buffer_pingpong: directed self-checking bench for frame_buffer_pingpong
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_frame_buffer_pingpong;

   localparam int AW = 15;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset, we, wFrameDone, oe, rFrameStart;
   logic [AW-1:0] wAddr, rAddr;
   logic [DW-1:0] wData;
   logic          wReady, rValid, frameReady, rBank;
   logic [DW-1:0] rData;
   logic [15:0]   dropCount;

   int total = 0;
   int bad   = 0;

   frame_buffer_pingpong dut (
      .clk         (clk),
      .reset       (reset),
      .we          (we),
      .wAddr       (wAddr),
      .wData       (wData),
      .wFrameDone  (wFrameDone),
      .wReady      (wReady),
      .oe          (oe),
      .rAddr       (rAddr),
      .rFrameStart (rFrameStart),
      .rData       (rData),
      .rValid      (rValid),
      .frameReady  (frameReady),
      .rBank       (rBank),
      .dropCount   (dropCount)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      we = 0; wFrameDone = 0; oe = 0; rFrameStart = 0; reset = 0;
   endtask

   initial begin
      idle();
      wAddr = '0; wData = '0; rAddr = '0;

      // Reset state
      reset = 1; step(); reset = 0;
      check("rst_rBank", rBank, 0);
      check("rst_wReady", wReady, 1);
      check("rst_frameReady", frameReady, 0);
      check("rst_dropCount", dropCount, 0);
      check("rst_rValid", rValid, 0);
      check("rst_rData", rData, 0);

      // Basic frame: write bank1 addr5, complete, swap, read back
      we = 1; wAddr = 5; wData = 16'h1234; step(); we = 0;
      wFrameDone = 1; step(); wFrameDone = 0;
      check("a_wReady", wReady, 0);
      check("a_frameReady", frameReady, 1);
      rFrameStart = 1; step(); rFrameStart = 0;
      check("a_rBank", rBank, 1);
      check("a_frameReady_clr", frameReady, 0);
      check("a_wReady_back", wReady, 1);
      oe = 1; rAddr = 5; step(); oe = 0;
      check("a_rData", rData, 16'h1234);
      check("a_rValid", rValid, 1);
      step();
      check("a_rValid_low", rValid, 0);
      check("a_rData_hold", rData, 16'h1234);

      // Blocked writer: fill bank0, wait, drop three frames
      we = 1; wAddr = 7; wData = 16'hAAAA; step();
      wAddr = 0; wData = 16'h5A5A; step(); we = 0;
      wFrameDone = 1; step(); wFrameDone = 0;
      check("b_wReady", wReady, 0);
      check("b_frameReady", frameReady, 1);
      we = 1; wAddr = 7; wData = 16'hBBBB; step(); we = 0;
      wFrameDone = 1; step(); step(); step(); wFrameDone = 0;
      check("b_dropCount", dropCount, 3);
      check("b_wReady_still", wReady, 0);
      rFrameStart = 1; step(); rFrameStart = 0;
      check("b_rBank", rBank, 0);
      check("b_dropCount_keep", dropCount, 3);
      oe = 1; rAddr = 7; step(); oe = 0;
      check("b_wait_write_dropped", rData, 16'hAAAA);

      // Same-cycle done+start from WRITE, read old bank on swap cycle
      reset = 1; step(); reset = 0;
      check("c_rst_dropCount", dropCount, 0);
      we = 1; wAddr = 0; wData = 16'h0C0C; step(); we = 0;
      rFrameStart = 1; check("c_noswap_pre", rBank, 0);
      step(); rFrameStart = 0;
      check("c_noswap_rBank", rBank, 0);
      check("c_noswap_wReady", wReady, 1);
      wFrameDone = 1; rFrameStart = 1; oe = 1; rAddr = 0;
      we = 1; wAddr = 9; wData = 16'h9999;
      step();
      wFrameDone = 0; rFrameStart = 0; we = 0;
      check("c_rBank", rBank, 1);
      check("c_frameReady", frameReady, 0);
      check("c_wReady", wReady, 1);
      check("c_dropCount", dropCount, 0);
      check("c_old_bank_read", rData, 16'h5A5A);
      step();
      check("c_new_bank_read", rData, 16'h0C0C);
      rAddr = 9; step(); oe = 0;
      check("c_swap_cycle_write", rData, 16'h9999);

      // Out-of-range address
      we = 1; wAddr = 15'd19200; wData = 16'hFFFF; step(); we = 0;
      oe = 1; rAddr = 15'd19200; step(); oe = 0;
      check("d_oor_rData", rData, 0);
      check("d_oor_rValid", rValid, 1);

      // Reset while waiting for swap with drops pending
      wFrameDone = 1; step(); step(); step(); wFrameDone = 0;
      check("e_dropCount", dropCount, 2);
      check("e_frameReady", frameReady, 1);
      reset = 1; wFrameDone = 1; rFrameStart = 1; step();
      reset = 0; wFrameDone = 0; rFrameStart = 0;
      check("e_rBank", rBank, 0);
      check("e_wReady", wReady, 1);
      check("e_frameReady", frameReady, 0);
      check("e_dropCount_clr", dropCount, 0);
      oe = 1; rAddr = 7; step();
      check("e_mem_kept7", rData, 16'hAAAA);
      rAddr = 0; step(); oe = 0;
      check("e_mem_kept0", rData, 16'h5A5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
